// File: rtl/servo_sched.sv
// servo_sched: four-channel servo pulse scheduler.
// One frame is four slots of SLOT_CYC cycles; channel c pulses during slot c
// for active_w[c] cycles. Writes land in a shadow target and are applied to
// the active widths only at a frame boundary.
// Build option: define SERVO_SLEW_EN to limit each frame-boundary width change
// to SLEW_STEP cycles; otherwise the active width jumps to the target.
// W_MIN / W_STEP set the index-to-width table (defaults give 25_000 ..
// 100_000 cycles in 18_750 steps).
module servo_sched #(
  parameter int SLOT_CYC  = 250_000,
  parameter int SLEW_STEP = 6_250,
  parameter int W_MIN     = 25_000,
  parameter int W_STEP    = 18_750
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       en,
  input  logic       pos_wr,
  input  logic [1:0] pos_ch,
  input  logic [2:0] pos_idx,
  output logic       pos_ack,
  output logic       pos_err,
  output logic [3:0] PWM,
  output logic [1:0] cur_ch,
  output logic       frame_start,
  output logic [3:0] settled
);

  localparam int CW = 18;  // slot counter width, covers SLOT_CYC up to 262_143
  localparam int WW = 17;  // pulse-width register width

  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [WW-1:0] W_CENTER  = WW'(W_MIN + 2 * W_STEP);
  localparam logic [WW-1:0] STEP      = WW'(SLEW_STEP);

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  // Position index to pulse width in cycles; out-of-range indices are never stored.
  function automatic logic [WW-1:0] idx_width(input logic [2:0] idx);
    case (idx)
      3'd0:    idx_width = WW'(W_MIN);
      3'd1:    idx_width = WW'(W_MIN + W_STEP);
      3'd2:    idx_width = WW'(W_MIN + 2 * W_STEP);
      3'd3:    idx_width = WW'(W_MIN + 3 * W_STEP);
      3'd4:    idx_width = WW'(W_MIN + 4 * W_STEP);
      default: idx_width = W_CENTER;
    endcase
  endfunction

  logic [CW-1:0] slot_cnt;
  logic [1:0]    ch_cnt;
  logic          en_d;

  logic [WW-1:0] target   [4];
  logic [WW-1:0] active_w [4];
  logic [WW-1:0] next_w   [4];

  logic       start;     // first enabled cycle: acts as a frame boundary
  logic       run;       // enabled for at least one full cycle: counters advance
  logic       slot_end;
  logic       boundary;
  logic       idx_ok;
  logic       wr_ok;
  logic [3:0] pwm_next;

  assign start    = en & ~en_d;
  assign run      = en & en_d;
  assign slot_end = (slot_cnt == SLOT_LAST);
  assign boundary = start | (run & slot_end & (ch_cnt == 2'd3));
  assign idx_ok   = (pos_idx <= 3'd4);
  assign wr_ok    = pos_wr & idx_ok;
  assign cur_ch   = ch_cnt;

  // Slot and channel counters; held at zero while disabled and during the start cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    if (!RST_N) begin
      slot_cnt <= '0;
      ch_cnt   <= '0;
      en_d     <= 1'b0;
    end else begin
      en_d <= en;
      if (!run) begin
        slot_cnt <= '0;
        ch_cnt   <= '0;
      end else if (slot_end) begin
        slot_cnt <= '0;
        ch_cnt   <= ch_cnt + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end
    end
  end

  // Width to load at the next boundary: the target, or one slew step toward it.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      // NOTE: every always_comb output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      next_w[c] = target[c];
      if (SLEW_ON) begin
        if ((target[c] > active_w[c]) && ((target[c] - active_w[c]) > STEP))
          next_w[c] = active_w[c] + STEP;
        else if ((active_w[c] > target[c]) && ((active_w[c] - target[c]) > STEP))
          next_w[c] = active_w[c] - STEP;
      end
    end
  end

  // Shadow targets take accepted writes; active widths load only on a boundary,
  // so a write on the boundary edge is seen one frame later.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: these width arrays are a handful of flops, not a RAM, so they are
    // reset explicitly; a real memory macro could not be cleared this way.
    if (!RST_N) begin
      for (int c = 0; c < 4; c++) begin
        target[c]   <= W_CENTER;
        active_w[c] <= W_CENTER;
      end
    end else begin
      if (wr_ok)
        target[pos_ch] <= idx_width(pos_idx);
      if (boundary)
        for (int c = 0; c < 4; c++)
          active_w[c] <= next_w[c];
    end
  end

  // Per-channel pulse request from the current counter position.
  always_comb begin
    pwm_next = '0;
    for (int c = 0; c < 4; c++)
      pwm_next[c] = run && (ch_cnt == 2'(c)) && (slot_cnt < {1'b0, active_w[c]});
  end

  // Registered outputs: pulses, write response and frame marker.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PWM         <= '0;
      pos_ack     <= 1'b0;
      pos_err     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      PWM         <= pwm_next;
      pos_ack     <= wr_ok;
      pos_err     <= pos_wr & ~idx_ok;
      frame_start <= boundary;
    end
  end

  // A channel is settled once its active width has reached its target.
  always_comb begin
    settled = '0;
    for (int c = 0; c < 4; c++)
      settled[c] = (active_w[c] == target[c]);
  end

endmodule

// File: tb/tb_servo_sched.sv
// tb_servo_sched: self-checking bench for servo_sched with a scaled-down
// timebase (slot 100 cycles, widths 20..80, slew step 5) so that many frames
// fit in a short run. A position-arithmetic model is compared every cycle;
// directed scenarios add literal width, offset and handshake expectations.
module tb_servo_sched;

  localparam int SLOT   = 100;
  localparam int FRAME  = 4 * SLOT;
  localparam int W_MIN  = 20;
  localparam int W_STEP = 15;
  localparam int SLEW   = 5;
  localparam int CENTER = W_MIN + 2 * W_STEP;

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_BUILD = 1'b1;
`else
  localparam bit SLEW_BUILD = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       en;
  logic       pos_wr;
  logic [1:0] pos_ch;
  logic [2:0] pos_idx;
  logic       pos_ack;
  logic       pos_err;
  logic [3:0] PWM;
  logic [1:0] cur_ch;
  logic       frame_start;
  logic [3:0] settled;

  servo_sched #(
    .SLOT_CYC (SLOT),
    .SLEW_STEP(SLEW),
    .W_MIN    (W_MIN),
    .W_STEP   (W_STEP)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .en         (en),
    .pos_wr     (pos_wr),
    .pos_ch     (pos_ch),
    .pos_idx    (pos_idx),
    .pos_ack    (pos_ack),
    .pos_err    (pos_err),
    .PWM        (PWM),
    .cur_ch     (cur_ch),
    .frame_start(frame_start),
    .settled    (settled)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos is the position inside the frame (0..FRAME-1) of the cycle after
  // the most recent edge; channel = m_pos / SLOT, slot offset = m_pos % SLOT.
  bit         m_valid = 1'b0;
  bit         m_run;
  int         m_pos;
  int         m_sh  [4];
  int         m_act [4];
  logic [3:0] m_pwm;
  logic [1:0] m_ch;
  logic       m_fs, m_ack, m_err;

  function automatic int width_of(input int idx);
    return W_MIN + idx * W_STEP;
  endfunction

  function automatic int frame_load(input int act, input int tgt);
    int d;
    if (!SLEW_BUILD) return tgt;
    d = (tgt > act) ? tgt - act : act - tgt;
    if (d > SLEW) d = SLEW;
    return (tgt > act) ? act + d : act - d;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_valid = 1'b1;
      m_run   = 1'b0;
      m_pos   = 0;
      m_pwm   = '0;
      m_ch    = '0;
      m_fs    = 1'b0;
      m_ack   = 1'b0;
      m_err   = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_sh[c]  = CENTER;
        m_act[c] = CENTER;
      end
    end else begin
      m_ack = pos_wr && (pos_idx <= 3'd4);
      m_err = pos_wr && (pos_idx > 3'd4);
      m_pwm = '0;
      m_fs  = 1'b0;
      if (!en) begin
        m_run = 1'b0;
        m_pos = 0;
      end else if (!m_run) begin
        for (int c = 0; c < 4; c++) m_act[c] = frame_load(m_act[c], m_sh[c]);
        m_run = 1'b1;
        m_pos = 0;
        m_fs  = 1'b1;
      end else begin
        for (int c = 0; c < 4; c++)
          m_pwm[c] = ((m_pos / SLOT) == c) && ((m_pos % SLOT) < m_act[c]);
        if (m_pos == FRAME - 1)
          for (int c = 0; c < 4; c++) m_act[c] = frame_load(m_act[c], m_sh[c]);
        m_pos = (m_pos + 1) % FRAME;
        m_fs  = (m_pos == 0);
      end
      m_ch = 2'(m_pos / SLOT);
      if (m_ack) m_sh[pos_ch] = width_of(int'(pos_idx));
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge CLK) begin
    logic [3:0] m_set;
    for (int c = 0; c < 4; c++) m_set[c] = (m_act[c] == m_sh[c]);
    if (m_valid)
      check("outputs", 32'({PWM, cur_ch, frame_start, settled, pos_ack, pos_err}),
                       32'({m_pwm, m_ch, m_fs, m_set, m_ack, m_err}));
  end

  // ---------------- pulse measurement ----------------
  int cyc = 0;
  int run_len   [4] = '{default: 0};
  int last_w    [4] = '{default: 0};
  int rise_cyc  [4] = '{default: 0};
  int rise_prev [4] = '{default: 0};

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    for (int c = 0; c < 4; c++) begin
      if (PWM[c]) begin
        if (run_len[c] == 0) begin
          rise_prev[c] = rise_cyc[c];
          rise_cyc[c]  = cyc;
        end
        run_len[c]++;
      end else if (run_len[c] != 0) begin
        last_w[c]  = run_len[c];
        run_len[c] = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!frame_start && n < 2 * FRAME);
    if (!frame_start) check("frame_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [2:0] idx);
    pos_wr  = 1'b1;
    pos_ch  = ch;
    pos_idx = idx;
    @(negedge CLK);
    pos_wr  = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    RST_N   = 1'b1;
    en      = 1'b0;
    pos_wr  = 1'b0;
    pos_ch  = '0;
    pos_idx = '0;
    #1 RST_N = 1'b0;
    wait_cycles(5);

    // Reset state.
    check("rst_pwm", 32'(PWM), 32'd0);
    check("rst_settled", 32'(settled), 32'hF);
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    check("rst_handshake", 32'({frame_start, pos_ack, pos_err}), 32'd0);

    // Release with en high: start cycle, then frame_start.
    RST_N = 1'b1;
    en    = 1'b1;
    @(negedge CLK);
    check("start_frame_start", 32'(frame_start), 32'd1);
    wait_cycles(1);
    wait_fs();
    wait_cycles(390);
    for (int c = 0; c < 4; c++) check("default_width", 32'(last_w[c]), 32'(CENTER));
    check("ch0_period", 32'(rise_cyc[0] - rise_prev[0]), 32'(FRAME));
    check("ch1_offset", 32'(rise_cyc[1] - rise_cyc[0]), 32'(SLOT));
    check("ch2_offset", 32'(rise_cyc[2] - rise_cyc[1]), 32'(SLOT));
    check("ch3_offset", 32'(rise_cyc[3] - rise_cyc[2]), 32'(SLOT));
    check("default_settled", 32'(settled), 32'hF);

    // Mid-frame write ch2 -> 180 deg: applies from the next frame only.
    wait_fs();
    do_write(2'd2, 3'd4);
    check("wr_ch2_ack", 32'({pos_ack, pos_err}), 32'b10);
    check("wr_ch2_unsettled", 32'(settled[2]), 32'd0);
    wait_cycles(389);
    check("ch2_same_frame", 32'(last_w[2]), 32'(CENTER));
    wait_fs();
    wait_cycles(390);
    check("ch2_next_frame", 32'(last_w[2]), SLEW_BUILD ? 32'd55 : 32'd80);
    check("model_ch2_active", 32'(m_act[2]), SLEW_BUILD ? 32'd55 : 32'd80);

    // Invalid index on ch1: err, no ack, width unchanged.
    wait_fs();
    do_write(2'd1, 3'd7);
    check("wr_ch1_err", 32'({pos_ack, pos_err}), 32'b01);
    check("wr_ch1_settled", 32'(settled[1]), 32'd1);
    wait_cycles(389);
    check("ch1_unchanged", 32'(last_w[1]), 32'(CENTER));

    // Write ch0 -> 0 deg on the boundary edge: applies one frame later.
    wait_fs();
    wait_cycles(FRAME - 1);
    do_write(2'd0, 3'd0);
    check("boundary_fs", 32'(frame_start), 32'd1);
    check("boundary_ack", 32'(pos_ack), 32'd1);
    wait_cycles(150);
    check("ch0_boundary_frame", 32'(last_w[0]), 32'(CENTER));
    wait_fs();
    wait_cycles(150);
    check("ch0_following_frame", 32'(last_w[0]), SLEW_BUILD ? 32'd45 : 32'd20);

    // ch3 90 -> 180 deg, followed over six frames.
    wait_fs();
    do_write(2'd3, 3'd4);
    for (int i = 0; i < 6; i++) begin
      wait_fs();
      wait_cycles(390);
      check("ch3_width", 32'(last_w[3]), SLEW_BUILD ? 32'(CENTER + SLEW * (i + 1)) : 32'd80);
      check("ch3_settled", 32'(settled[3]), SLEW_BUILD ? 32'(i == 5) : 32'd1);
    end

    // Drop en mid-pulse: PWM low next cycle, writes still accepted.
    wait_fs();
    wait_cycles(10);
    check("pre_drop_pwm0", 32'(PWM[0]), 32'd1);
    en = 1'b0;
    @(negedge CLK);
    check("en_drop_pwm", 32'(PWM), 32'd0);
    check("en_drop_cur_ch", 32'(cur_ch), 32'd0);
    do_write(2'd1, 3'd0);
    check("disabled_wr_ack", 32'(pos_ack), 32'd1);
    check("disabled_ch1_unsettled", 32'(settled[1]), 32'd0);
    wait_cycles(5);
    check("disabled_pwm", 32'(PWM), 32'd0);
    en = 1'b1;
    @(negedge CLK);
    check("restart_fs", 32'(frame_start), 32'd1);
    check("restart_ch1_settled", 32'(settled[1]), SLEW_BUILD ? 32'd0 : 32'd1);

    // Asynchronous reset in the middle of the ch1 pulse.
    wait_cycles(105);
    check("pre_reset_pwm1", 32'(PWM[1]), 32'd1);
    #1 RST_N = 1'b0;
    #1 check("async_reset_pwm", 32'(PWM), 32'd0);
    @(negedge CLK);
    check("reset_pwm", 32'(PWM), 32'd0);
    check("reset_settled", 32'(settled), 32'hF);
    wait_cycles(3);
    RST_N = 1'b1;
    wait_fs();
    wait_cycles(390);
    for (int c = 0; c < 4; c++) check("post_reset_width", 32'(last_w[c]), 32'(CENTER));
    check("model_ch0_active", 32'(m_act[0]), 32'(CENTER));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_sched.md
SERVO_SCHED -- requirements
Module: servo_sched

Interface
REQ-001 Parameter SLOT_CYC, default 250_000, clock cycles per channel slot; the block SHALL support any value from 100_001 to 262_143.
REQ-002 Parameter SLEW_STEP, default 6_250, maximum pulse-width change per frame in cycles when slew is enabled.
REQ-003 CLK  input  1  system clock, 50 MHz.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  scheduler enable.
REQ-006 pos_wr  input  1  position write strobe, single-cycle.
REQ-007 pos_ch  input  2  channel addressed by pos_wr.
REQ-008 pos_idx  input  3  position index: 0=0°, 1=45°, 2=90°, 3=135°, 4=180°.
REQ-009 pos_ack  output  1  one-cycle pulse confirming an accepted write.
REQ-010 pos_err  output  1  one-cycle pulse flagging a rejected write.
REQ-011 PWM  output  4  per-channel servo pulse.
REQ-012 cur_ch  output  2  channel owning the current slot.
REQ-013 frame_start  output  1  one-cycle pulse on the first cycle of each frame.
REQ-014 settled  output  4  per channel, 1 when the active width equals the target width.

Function
REQ-015 The block SHALL keep a slot counter (0..SLOT_CYC-1) and a channel counter (0..3); a frame SHALL be 4 slots, which is 1_000_000 cycles at the default SLOT_CYC.
REQ-016 The slot counter SHALL wrap to 0 and the channel counter SHALL increment (3 wraps to 0) on the cycle after the slot counter reaches SLOT_CYC-1.
REQ-017 The block SHALL map each index to a target width: 0->25_000, 1->43_750, 2->62_500, 3->81_250, 4->100_000 cycles; all width registers SHALL be 17 bits wide.
REQ-018 PWM[c] SHALL be registered and equal (cur_ch==c && slot_cnt < active_w[c]), giving one cycle of latency; the other three PWM bits SHALL be 0 during slot c.
REQ-019 A pos_wr with pos_idx<=4 SHALL update shadow target[pos_ch] at that clock edge and SHALL assert pos_ack on the next cycle.
REQ-020 A pos_wr with pos_idx>4 SHALL leave the shadow target unchanged and SHALL assert pos_err on the next cycle instead of pos_ack.
REQ-021 pos_wr SHALL need no wait state; each strobe SHALL be answered by exactly one ack or err pulse; with writes on consecutive cycles, the last write to a channel wins.
REQ-022 On the frame boundary (channel 3, slot_cnt==SLOT_CYC-1), active_w SHALL load from the shadow targets, or be slewed per REQ-031.
REQ-023 frame_start SHALL pulse on the first cycle of channel-0 slot 0.
REQ-024 A write landing on the frame-boundary edge SHALL update the shadow only; active_w SHALL take the pre-write shadow, and the new value SHALL apply at the next boundary.
REQ-025 With en=0, the counters SHALL be held at 0 and PWM SHALL be 0000, while writes are still accepted into the shadow.
REQ-026 On the first cycle after en rises, the block SHALL treat that cycle as a frame boundary: it SHALL load active_w and frame_start SHALL pulse on the following cycle.
REQ-027 en falling mid-pulse SHALL drive PWM low on the next cycle, truncating the pulse.
REQ-028 settled[c] SHALL be updated combinationally from the active_w and target registers.

Reset
REQ-029 While RST_N=0, the block SHALL force: PWM=0000, pos_ack=0, pos_err=0, frame_start=0, cur_ch=0, slot counter 0, every shadow target and active_w=62_500 (90°), settled=1111.
REQ-030 Reset asserted mid-frame or mid-pulse SHALL take effect immediately (asynchronously); after RST_N rises with en=1, the first frame SHALL begin per REQ-026.

Configuration
REQ-031 With SERVO_SLEW_EN defined, the frame-boundary load SHALL move each active_w toward its target by min(|target-active_w|, SLEW_STEP); without it, active_w SHALL jump directly to the target.

Verification
REQ-032 Reset, en=1, no writes -> each channel pulses 62_500 cycles once per 1_000_000 cycles; channel pulses are offset by 250_000 cycles; settled=1111.
REQ-033 Write ch2 idx4 mid-frame -> pos_ack next cycle; the ch2 pulse stays 62_500 until the next frame_start, then becomes 100_000 (slew off).
REQ-034 Write ch1 idx7 -> pos_err next cycle, no pos_ack, ch1 width unchanged.
REQ-035 Write ch0 idx0 on the boundary cycle -> next frame ch0=62_500, the frame after that 25_000.
REQ-036 SERVO_SLEW_EN defined, ch3 90°->180° -> widths 68_750, 75_000, …, 100_000 over 6 frames; settled[3]=0 until the 100_000 frame.
REQ-037 Drop en mid-pulse, then assert RST_N=0 mid-frame -> PWM=0000 the next cycle; after reset all widths are 62_500.
